// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-output static/PWM driver with period-aligned duty shadow
//
// Purpose:
//   Drives 16 chip outputs from the SPI-side configuration registers. Each
//   output is either forced low, held static high, or follows one shared
//   8-bit PWM waveform. The duty value is shadowed and only updated at a
//   PWM period boundary, so duty changes never glitch the running period.
//
// Parameters:
//   PRESCALE        clk cycles per PWM counter step (1..65535); one PWM
//                   period lasts 256*PRESCALE clk.
//
// Ports:
//   clk             fast system clock
//   rst             synchronous, active-high reset
//   en_reg_out_7_0  output enable, outputs 7..0
//   en_reg_out_15_8 output enable, outputs 15..8
//   en_reg_pwm_7_0  PWM select, outputs 7..0
//   en_reg_pwm_15_8 PWM select, outputs 15..8
//   pwm_duty_cycle  requested duty in 1/256 units, 0xFF means 100 %
//   out             registered chip outputs, bit i = output i
//   period_start    one-clk pulse on the first cycle of each PWM period
//   duty_active     duty value currently in effect

module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start,
  output logic [7:0]  duty_active
);

  // A single-step prescaler still needs a 1-bit counter to keep the
  // declarations legal; it then compares against 0 and ticks every cycle.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_prescale_cnt;
  logic [7:0]      r_pwm_cnt;
  logic [7:0]      r_duty_active;
  logic [15:0]     r_out;
  logic            r_period_start;

  logic            w_tick;
  logic            w_wrap;
  logic            w_pwm_level;
  logic [15:0]     w_en_out;
  logic [15:0]     w_en_pwm;
  logic [15:0]     w_out_next;

  assign w_tick = (r_prescale_cnt == PS_LAST);
  assign w_wrap = w_tick && (r_pwm_cnt == 8'hFF);

  // 0xFF is forced high so full duty has no low step at pwm_cnt == 255.
  assign w_pwm_level = (r_duty_active == 8'hFF) || (r_pwm_cnt < r_duty_active);

  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Disabled -> 0, enabled static -> 1, enabled PWM -> shared level.
  assign w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_level}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale_cnt <= '0;
      r_pwm_cnt      <= 8'h00;
      r_duty_active  <= 8'h00;
      r_out          <= 16'h0000;
      r_period_start <= 1'b0;
    end else begin
      r_prescale_cnt <= w_tick ? '0 : r_prescale_cnt + 1'b1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
      // Whatever duty is presented on the wrap cycle is the one that runs
      // for the whole next period; earlier mid-period writes are dropped.
      if (w_wrap) begin
        r_duty_active <= pwm_duty_cycle;
      end
      // Registered from wrap so it lines up with the first pwm_cnt == 0 cycle.
      r_period_start <= w_wrap;
      r_out          <= w_out_next;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;
  assign duty_active  = r_duty_active;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - directed self-checking bench for pwm_peripheral

module tb_pwm_peripheral;

  localparam int PRESCALE = 13;
  localparam int PERIOD   = 256 * PRESCALE;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;
  logic [7:0]  duty_active;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start),
    .duty_active     (duty_active)
  );

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] exp_out;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  task automatic wait_ps(input string name, output int n);
    n = 0;
    while (!period_start && n < 2 * PERIOD) begin
      step();
      n++;
    end
    check({name, " reached"}, period_start, 1);
  endtask

  // Starts on a period_start sample and walks to the next one, classifying
  // every sampled out word. Sample 0 still shows the level of the last
  // cycle of the previous period because out is registered.
  task automatic measure(input string name, input int exp_high, input int exp_low,
                         input int c1_at, input logic [7:0] c1_val,
                         input int c2_at, input logic [7:0] c2_val,
                         output logic [7:0] last_duty);
    int hi;
    int lo;
    int other;
    int n;
    hi = 0; lo = 0; other = 0; n = 0;
    last_duty = 8'h00;
    do begin
      if (n == c1_at) duty = c1_val;
      if (n == c2_at) duty = c2_val;
      if (out === 16'hFFFF) hi++;
      else if (out === 16'h0000) lo++;
      else other++;
      last_duty = duty_active;
      step();
      n++;
    end while (!period_start && n < 2 * PERIOD);
    check({name, " high"}, hi, exp_high);
    check({name, " low"}, lo, exp_low);
    check({name, " other"}, other, 0);
    check({name, " spacing"}, n, PERIOD);
  endtask

  initial begin
    int n;
    logic [7:0] ld;

    tbl[0] = '{16'h00FF, 16'h0000, 16'h00FF};
    tbl[1] = '{16'h0000, 16'hFFFF, 16'h0000};
    tbl[2] = '{16'hF0F0, 16'h00F0, 16'hF000};
    tbl[3] = '{16'hFFFF, 16'hAAAA, 16'h5555};
    tbl[4] = '{16'h1234, 16'h0000, 16'h1234};
    tbl[5] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    tbl[6] = '{16'h8001, 16'h8000, 16'h0001};

    // Reset with everything enabled and a nonzero duty request.
    rst = 1'b1;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    step();
    check("rst1 out", out, 16'h0000);
    check("rst1 duty_active", duty_active, 8'h00);
    check("rst1 period_start", period_start, 1'b0);
    step();
    check("rst2 out", out, 16'h0000);
    check("rst2 duty_active", duty_active, 8'h00);
    check("rst2 period_start", period_start, 1'b0);
    rst = 1'b0;
    step();
    check("post-rst out", out, 16'h0000);
    check("post-rst duty_active", duty_active, 8'h00);
    check("post-rst period_start", period_start, 1'b0);

    // Mux table during the first period, where the PWM level is 0.
    for (int i = 0; i < 7; i++) begin
      set_en(tbl[i].en_out, tbl[i].en_pwm);
      step();
      check($sformatf("vec%0d out", i), out, tbl[i].exp_out);
      step();
      step();
      check($sformatf("vec%0d hold", i), out, tbl[i].exp_out);
    end

    // First wrap lands 3328 edges after the last reset edge:
    // 1 release step + 21 table steps + 3306.
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    wait_ps("first wrap", n);
    check("first period length", n, 3306);
    check("first load duty_active", duty_active, 8'h80);

    measure("50pct w1", 1664, 1664, -1, 8'h00, -1, 8'h00, ld);
    check("50pct duty_active", duty_active, 8'h80);
    measure("50pct w2", 1664, 1664, -1, 8'h00, -1, 8'h00, ld);
    measure("pre-zero", 1664, 1664, 0, 8'h00, -1, 8'h00, ld);
    check("zero duty_active", duty_active, 8'h00);
    measure("zero p1", 0, 3328, -1, 8'h00, -1, 8'h00, ld);
    measure("zero p2", 0, 3328, -1, 8'h00, -1, 8'h00, ld);
    measure("zero p3", 0, 3328, 0, 8'hFF, -1, 8'h00, ld);
    check("full duty_active", duty_active, 8'hFF);
    // First full-duty window: sample 0 still shows the low 0x00 level.
    measure("full p1", 3327, 1, -1, 8'h00, -1, 8'h00, ld);
    measure("full p2", 3328, 0, -1, 8'h00, -1, 8'h00, ld);
    measure("full p3", 3328, 0, 0, 8'h40, -1, 8'h00, ld);
    check("quarter duty_active", duty_active, 8'h40);
    // 64*13 = 832 high, plus sample 0 carrying the previous 0xFF level.
    measure("quarter settle", 833, 2495, -1, 8'h00, -1, 8'h00, ld);

    // 0xC0 written at pwm_cnt 0x20 (0x20*13 = 416 cycles in).
    measure("midupd cur", 832, 2496, 416, 8'hC0, -1, 8'h00, ld);
    check("midupd duty held", ld, 8'h40);
    check("midupd duty_active", duty_active, 8'hC0);
    measure("midupd next", 2496, 832, 100, 8'h10, 2000, 8'h30, ld);
    check("midupd next duty held", ld, 8'hC0);
    check("last wins duty_active", duty_active, 8'h30);
    measure("last wins", 624, 2704, 0, 8'h80, -1, 8'h00, ld);
    check("mixed duty_active", duty_active, 8'h80);

    // Mixed enables: 15..12 static, 7..4 PWM, the rest off.
    set_en(16'hF0F0, 16'h00F0);
    step();
    check("mixed pwm high", out, 16'hF0F0);
    for (int k = 1; k < 1700; k++) step();
    check("mixed pwm low", out, 16'hF000);
    wait_ps("mixed wrap", n);
    check("mixed wrap distance", n, 1628);
    for (int k = 0; k < 1040; k++) step();
    check("pre-rst pwm high", out, 16'hF0F0);
    rst = 1'b1;
    step();
    check("midrst out", out, 16'h0000);
    check("midrst duty_active", duty_active, 8'h00);
    check("midrst period_start", period_start, 1'b0);
    rst = 1'b0;
    step();
    check("after midrst out", out, 16'hF000);
    wait_ps("restart wrap", n);
    check("restart period length", n, 3327);
    check("restart duty_active", duty_active, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration registers produced by the SPI register block: output enables, PWM enables, duty cycle.
- Drives the 16 chip outputs.
- Each output is one of: forced low, static high, or a shared 8-bit PWM waveform.
- Single clock domain (fast clk). Duty changes are glitch-free and take effect at period boundaries.

Parameters:
- PRESCALE, 13, clk cycles per PWM counter step; PWM period = 256*PRESCALE clk (~3 kHz at 10 MHz). Legal range 1..65535.

Ports:
- clk  input  1  fast system clock
- rst  input  1  synchronous, active-high reset
- en_reg_out_7_0  input  8  output enable, outputs 7..0
- en_reg_out_15_8  input  8  output enable, outputs 15..8
- en_reg_pwm_7_0  input  8  PWM select, outputs 7..0
- en_reg_pwm_15_8  input  8  PWM select, outputs 15..8
- pwm_duty_cycle  input  8  requested duty, in 1/256 units; 0xFF = 100 %
- out  output  16  registered chip outputs; bit i = output i
- period_start  output  1  one-clk pulse on the first cycle of each PWM period
- duty_active  output  8  duty value currently in effect (shadow register)

Behaviour:
- Reset is synchronous, active-high, sampled on posedge clk. All state clears on reset:
  - prescale_cnt = 0, pwm_cnt = 0, duty_active = 0x00, out = 0x0000, period_start = 0.
- Prescaler:
  - prescale_cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick = (prescale_cnt == PRESCALE-1).
  - PRESCALE=1 gives tick every cycle.
- PWM counter:
  - 8-bit pwm_cnt increments on tick.
  - Wraps 255 -> 0 with no stall.
- Period boundary: wrap = tick && pwm_cnt == 255. On wrap:
  - duty_active <= pwm_duty_cycle (sampled that cycle).
  - period_start <= 1 for exactly one clk, coincident with the first cycle where pwm_cnt == 0.
- Duty changes mid-period:
  - Never alter the current period.
  - The last value present at the wrap cycle wins.
  - Intermediate values are discarded.
- PWM level (combinational):
  - pwm_level = 1 if duty_active == 0xFF.
  - Otherwise pwm_level = (pwm_cnt < duty_active).
  - 0x00 gives constant low; 0xFF gives constant high (no 1-step glitch).
  - Otherwise high time = duty_active*PRESCALE clk per period.
- Output mux per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i] = 0 -> 0, regardless of en_pwm[i].
  - en_out[i] = 1, en_pwm[i] = 0 -> 1.
  - en_out[i] = 1, en_pwm[i] = 1 -> pwm_level.
- Output timing:
  - out is registered: one clk latency from enable inputs or pwm_cnt/duty_active state to out.
  - Enable changes are NOT period-aligned; they apply on the next clk edge.
- All PWM-selected outputs share one counter and are phase-aligned; no per-channel phase offset.
- Inputs are treated as synchronous to clk (upstream register block is in the same domain); no synchronizers.
- Reset mid-period:
  - Counters and shadow clear immediately.
  - Outputs go low on the reset cycle.
  - After rst deasserts, the first period runs with duty_active = 0; the new duty is loaded at the first wrap, 256*PRESCALE clk later.
- No arithmetic overflow anywhere: counter widths are exact, and prescale_cnt is sized to ceil(log2(PRESCALE)) bits, minimum 1.

Test Plan:
- Reset/defaults:
  - Stimulus: assert rst 2 clk with all enables 0xFF and duty 0x80.
  - Response: out = 0x0000, duty_active = 0x00, period_start = 0 during reset and for one clk after.
- Static mode:
  - Stimulus: en_out = 0x00FF, en_pwm = 0x0000.
  - Response: out = 0x00FF one clk later and held indefinitely.
  - Then en_out = 0x0000, en_pwm = 0xFFFF -> out = 0x0000.
- 50 % duty:
  - Stimulus: PRESCALE = 13, en_out = en_pwm = 0xFFFF, duty = 0x80, wait one period.
  - Response: per period, out = 0xFFFF for exactly 1664 clk and 0x0000 for 1664 clk; period_start spacing exactly 3328 clk.
- Extremes:
  - duty = 0x00 -> out stays 0x0000 across 3 full periods.
  - duty = 0xFF -> out stays 0xFFFF across 3 full periods, with no low cycle at pwm_cnt = 255.
- Mid-period update:
  - Stimulus: duty_active = 0x40; write duty 0xC0 at pwm_cnt = 0x20.
  - Response: current period high time is unchanged (832 clk); duty_active = 0xC0 exactly on the period_start cycle; next period high time is 2496 clk.
  - Writing 0x10 then 0x30 within one period -> only 0x30 is loaded.
- Mixed enables plus reset mid-operation:
  - Stimulus: en_out = 0xF0F0, en_pwm = 0x00F0, duty = 0x80.
  - Response: bits 15..12 static high, bits 7..4 toggle, all others low.
  - Assert rst at pwm_cnt = 0x50: out = 0x0000 next clk, and the counter restarts from 0 after release.
